ddr4_app_master: RTL and testbench

DDR4_APP_MASTER -- requirements
Module: ddr4_app_master

---
 rtl/ddr4_app_pkg.sv | 18 +
 rtl/ddr4_app_rd_fifo.sv | 48 ++++
 rtl/ddr4_app_master.sv | 187 ++++++++++++++++++
 tb/tb_ddr4_app_master.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_app_pkg.sv
// Shared definitions for the DDR4 MIG application-port master:
// default widths, MIG app command codes and the master FSM states.
package ddr4_app_pkg;

   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 640;

   localparam logic [2:0] APP_CMD_WR = 3'b000;
   localparam logic [2:0] APP_CMD_RD = 3'b001;

   typedef enum logic [1:0] {
      ST_CALIB = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } state_t;

endpackage

// File: rtl/ddr4_app_rd_fifo.sv
// Read-return FIFO: holds MIG read beats until the user takes them.
// A push is accepted when full only if a pop happens in the same cycle.
module ddr4_app_rd_fifo #(
   parameter int DATA_W = 640,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_push_ok;
   logic              w_pop_ok;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; data array needs no reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/ddr4_app_master.sv
// DDR4 MIG application-port master: turns single user read/write requests
// into MIG app commands, buffers read returns and limits outstanding reads
// with a credit counter sized to the return FIFO.
// Optional build macro: DDR4_APP_MASTER_STATS_EN enables the issued-command
// counters stat_wr_cnt/stat_rd_cnt; without it both outputs are tied to 0.
module ddr4_app_master
   import ddr4_app_pkg::*;
#(
   parameter int  ADDR_W   = DEF_ADDR_W,
   parameter int  DATA_W   = DEF_DATA_W,
   parameter int  RD_DEPTH = 16,
   localparam int MASK_W   = DATA_W / 8
) (
   input  logic              c0_ddr4_ui_clk,
   input  logic              sys_rst,
   input  logic              c0_init_calib_complete,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_wmask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] c0_ddr4_app_addr,
   output logic [2:0]        c0_ddr4_app_cmd,
   output logic              c0_ddr4_app_en,
   output logic              c0_ddr4_app_hi_pri,
   output logic [DATA_W-1:0] c0_ddr4_app_wdf_data,
   output logic [MASK_W-1:0] c0_ddr4_app_wdf_mask,
   output logic              c0_ddr4_app_wdf_wren,
   output logic              c0_ddr4_app_wdf_end,
   input  logic              c0_ddr4_app_rdy,
   input  logic              c0_ddr4_app_wdf_rdy,
   input  logic              c0_ddr4_app_rd_data_valid,
   input  logic              c0_ddr4_app_rd_data_end,
   input  logic [DATA_W-1:0] c0_ddr4_app_rd_data,
   output logic [31:0]       stat_wr_cnt,
   output logic [31:0]       stat_rd_cnt
);

   localparam int CW = $clog2(RD_DEPTH) + 1;

   state_t            r_state;
   logic [CW-1:0]     r_credit;
   logic              r_app_en;
   logic [2:0]        r_app_cmd;
   logic [ADDR_W-1:0] r_app_addr;
   logic              r_wdf_wren;
   logic [DATA_W-1:0] r_wdf_data;
   logic [MASK_W-1:0] r_wdf_mask;

   logic w_req_ready;
   logic w_accept;
   logic w_cmd_ok;
   logic w_data_ok;
   logic w_fifo_empty;
   logic w_fifo_full;
   logic w_pop;
   logic w_credit_dec;
   logic w_unused;

   assign w_req_ready  = (r_state == ST_IDLE) & c0_init_calib_complete & (r_credit != '0);
   assign w_accept     = req_valid & w_req_ready;
   // A side is finished once its enable is low or it is being accepted now.
   assign w_cmd_ok     = ~r_app_en | c0_ddr4_app_rdy;
   assign w_data_ok    = ~r_wdf_wren | c0_ddr4_app_wdf_rdy;
   assign w_pop        = ~w_fifo_empty & rsp_ready;
   assign w_credit_dec = w_accept & ~req_write;
   // MIG delivers one beat per read command, so the end flag carries nothing;
   // credits keep the FIFO from filling, so its full flag is informational.
   assign w_unused     = c0_ddr4_app_rd_data_end | w_fifo_full;

   assign req_ready            = w_req_ready;
   assign rsp_valid            = ~w_fifo_empty;
   assign c0_ddr4_app_addr     = r_app_addr;
   assign c0_ddr4_app_cmd      = r_app_cmd;
   assign c0_ddr4_app_en       = r_app_en;
   assign c0_ddr4_app_hi_pri   = 1'b0;
   assign c0_ddr4_app_wdf_data = r_wdf_data;
   assign c0_ddr4_app_wdf_mask = r_wdf_mask;
   assign c0_ddr4_app_wdf_wren = r_wdf_wren;
   assign c0_ddr4_app_wdf_end  = r_wdf_wren;

   // Control FSM with registered app command/write-data strobes.
   always_ff @(posedge c0_ddr4_ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_state    <= ST_CALIB;
         r_app_en   <= 1'b0;
         r_app_cmd  <= APP_CMD_WR;
         r_app_addr <= '0;
         r_wdf_wren <= 1'b0;
      end else begin
         case (r_state)
            ST_CALIB: begin
               if (c0_init_calib_complete) r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (!c0_init_calib_complete) begin
                  r_state <= ST_CALIB;
               end else if (w_accept) begin
                  r_app_en   <= 1'b1;
                  r_app_cmd  <= req_write ? APP_CMD_WR : APP_CMD_RD;
                  r_app_addr <= req_addr;
                  r_wdf_wren <= req_write;
                  r_state    <= req_write ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE: begin
               if (c0_ddr4_app_rdy)     r_app_en   <= 1'b0;
               if (c0_ddr4_app_wdf_rdy) r_wdf_wren <= 1'b0;
               if (w_cmd_ok && w_data_ok)
                  r_state <= c0_init_calib_complete ? ST_IDLE : ST_CALIB;
            end
            ST_READ: begin
               if (c0_ddr4_app_rdy) begin
                  r_app_en <= 1'b0;
                  r_state  <= c0_init_calib_complete ? ST_IDLE : ST_CALIB;
               end
            end
            default: r_state <= ST_CALIB;
         endcase
      end
   end

   // Write beat capture at acceptance; held until the next write request.
   always_ff @(posedge c0_ddr4_ui_clk) begin
      if (w_accept && req_write) begin
         r_wdf_data <= req_wdata;
         r_wdf_mask <= req_wmask;
      end
   end

   // Read credits: one per free FIFO slot, reserved when a read is accepted.
   always_ff @(posedge c0_ddr4_ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_credit <= CW'(RD_DEPTH);
      end else begin
         case ({w_credit_dec, w_pop})
            2'b10:   r_credit <= r_credit - CW'(1);
            2'b01:   r_credit <= r_credit + CW'(1);
            default: r_credit <= r_credit;
         endcase
      end
   end

   ddr4_app_rd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RD_DEPTH)
   ) u_rd_fifo (
      .clk     (c0_ddr4_ui_clk),
      .rst_n   (sys_rst),
      .i_push  (c0_ddr4_app_rd_data_valid),
      .i_data  (c0_ddr4_app_rd_data),
      .i_pop   (w_pop),
      .o_data  (rsp_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

`ifdef DDR4_APP_MASTER_STATS_EN
   logic [31:0] r_stat_wr;
   logic [31:0] r_stat_rd;

   // Saturating counts of app commands taken by the MIG.
   always_ff @(posedge c0_ddr4_ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_stat_wr <= '0;
         r_stat_rd <= '0;
      end else if (r_app_en && c0_ddr4_app_rdy) begin
         if (r_app_cmd == APP_CMD_WR) begin
            if (r_stat_wr != 32'hFFFF_FFFF) r_stat_wr <= r_stat_wr + 32'd1;
         end else begin
            if (r_stat_rd != 32'hFFFF_FFFF) r_stat_rd <= r_stat_rd + 32'd1;
         end
      end
   end

   assign stat_wr_cnt = r_stat_wr;
   assign stat_rd_cnt = r_stat_rd;
`else
   assign stat_wr_cnt = '0;
   assign stat_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr4_app_master.sv
// Bench for ddr4_app_master: directed scenarios plus randomized traffic
// against a memory-level reference model and a simple MIG responder.
module tb_ddr4_app_master;
   import ddr4_app_pkg::*;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 640;
   localparam int MASK_W = DATA_W / 8;

   logic              clk;
   logic              sys_rst;
   logic              calib;
   logic              req_valid, req_ready, req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [MASK_W-1:0] req_wmask;
   logic              rsp_valid, rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] app_addr;
   logic [2:0]        app_cmd;
   logic              app_en, app_hi_pri;
   logic [DATA_W-1:0] wdf_data;
   logic [MASK_W-1:0] wdf_mask;
   logic              wdf_wren, wdf_end;
   logic              app_rdy, wdf_rdy, rd_valid, rd_end;
   logic [DATA_W-1:0] rd_data;
   logic [31:0]       stat_wr, stat_rd;

   ddr4_app_master dut (
      .c0_ddr4_ui_clk            (clk),
      .sys_rst                   (sys_rst),
      .c0_init_calib_complete    (calib),
      .req_valid                 (req_valid),
      .req_ready                 (req_ready),
      .req_write                 (req_write),
      .req_addr                  (req_addr),
      .req_wdata                 (req_wdata),
      .req_wmask                 (req_wmask),
      .rsp_valid                 (rsp_valid),
      .rsp_ready                 (rsp_ready),
      .rsp_data                  (rsp_data),
      .c0_ddr4_app_addr          (app_addr),
      .c0_ddr4_app_cmd           (app_cmd),
      .c0_ddr4_app_en            (app_en),
      .c0_ddr4_app_hi_pri        (app_hi_pri),
      .c0_ddr4_app_wdf_data      (wdf_data),
      .c0_ddr4_app_wdf_mask      (wdf_mask),
      .c0_ddr4_app_wdf_wren      (wdf_wren),
      .c0_ddr4_app_wdf_end       (wdf_end),
      .c0_ddr4_app_rdy           (app_rdy),
      .c0_ddr4_app_wdf_rdy       (wdf_rdy),
      .c0_ddr4_app_rd_data_valid (rd_valid),
      .c0_ddr4_app_rd_data_end   (rd_end),
      .c0_ddr4_app_rd_data       (rd_data),
      .stat_wr_cnt               (stat_wr),
      .stat_rd_cnt               (stat_rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int app_pct  = 100;
   int wdf_pct  = 100;
   int rsp_pct  = 100;
   int rd_lat   = 5;
   int n_wr_cmd = 0;
   int n_rd_cmd = 0;
   int cnt_en   = 0;
   int cnt_wren = 0;

   typedef struct { bit wr; logic [ADDR_W-1:0] addr; } cmd_t;
   typedef struct { int due; logic [DATA_W-1:0] d; } ret_t;

   cmd_t              cmd_q[$];
   logic [DATA_W-1:0] wd_q[$];
   logic [MASK_W-1:0] wm_q[$];
   logic [DATA_W-1:0] exp_rsp_q[$];
   ret_t              ret_q[$];
   logic [ADDR_W-1:0] mig_wa_q[$];
   logic [DATA_W-1:0] mig_wd_q[$];
   logic [MASK_W-1:0] mig_wm_q[$];
   logic [DATA_W-1:0] ref_mem[int];
   logic [DATA_W-1:0] mig_mem[int];

   task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] init_val(input int a);
      logic [31:0] w;
      w = 32'(a) ^ 32'hC0DE_0000;
      return {20{w}};
   endfunction

   // Bytes whose mask bit is 0 take the new data; masked bytes keep old data.
   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [MASK_W-1:0] m);
      logic [DATA_W-1:0] r;
      r = old;
      for (int i = 0; i < MASK_W; i++)
         if (!m[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [MASK_W-1:0] rand_mask();
      logic [MASK_W-1:0] m;
      for (int i = 0; i < MASK_W; i++) m[i] = ($urandom_range(3) == 0);
      return m;
   endfunction

   // ---------------- MIG responder (drives away from the edge) ----------------
   initial begin
      app_rdy = 1'b0; wdf_rdy = 1'b0; rd_valid = 1'b0; rd_end = 1'b0;
      rd_data = '0; rsp_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         app_rdy   = ($urandom_range(99) < app_pct);
         wdf_rdy   = ($urandom_range(99) < wdf_pct);
         rsp_ready = ($urandom_range(99) < rsp_pct);
         if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            rd_valid = 1'b1; rd_end = 1'b1; rd_data = ret_q[0].d;
            void'(ret_q.pop_front());
         end else begin
            rd_valid = 1'b0; rd_end = 1'b0; rd_data = '0;
         end
      end
   end

   // ---------------- monitor: handshakes at the coming posedge ----------------
   initial begin
      bit                prev_acc, prev_en, prev_wr;
      logic [ADDR_W-1:0] h_addr;
      logic [2:0]        h_cmd;
      logic [DATA_W-1:0] h_data;
      logic [MASK_W-1:0] h_mask;
      int                last_due, due, a;
      cmd_t              c;
      prev_acc = 0; prev_en = 0; prev_wr = 0; last_due = 0;
      forever begin
         @(negedge clk); #2;
         cyc++;
         if (!sys_rst) begin
            prev_acc = 0; prev_en = 0; prev_wr = 0; last_due = 0;
            cmd_q.delete(); wd_q.delete(); wm_q.delete(); exp_rsp_q.delete();
            ret_q.delete(); mig_wa_q.delete(); mig_wd_q.delete(); mig_wm_q.delete();
            continue;
         end
         if (prev_acc) chk("issue_latency", app_en, 1);
         if (prev_en) begin
            chk("app_en_hold", app_en, 1);
            chk("app_addr_hold", app_addr, h_addr);
            chk("app_cmd_hold", app_cmd, h_cmd);
         end
         if (prev_wr) begin
            chk("wren_hold", wdf_wren, 1);
            chk("wdf_data_hold", wdf_data, h_data);
            chk("wdf_mask_hold", wdf_mask, h_mask);
         end
         cnt_en   += int'(app_en);
         cnt_wren += int'(wdf_wren);

         prev_acc = req_valid & req_ready;
         if (prev_acc) begin
            a = int'(req_addr);
            cmd_q.push_back('{req_write, req_addr});
            if (req_write) begin
               wd_q.push_back(req_wdata);
               wm_q.push_back(req_wmask);
               ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : init_val(a), req_wdata, req_wmask);
            end else begin
               exp_rsp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : init_val(a));
            end
         end

         if (app_en && app_rdy) begin
            chk("cmd_expected", cmd_q.size() != 0, 1);
            if (cmd_q.size() != 0) begin
               c = cmd_q.pop_front();
               chk("app_cmd", app_cmd, c.wr ? 3'b000 : 3'b001);
               chk("app_addr", app_addr, c.addr);
            end
            if (app_cmd == 3'b000) begin
               n_wr_cmd++;
               mig_wa_q.push_back(app_addr);
            end else begin
               n_rd_cmd++;
               a   = int'(app_addr);
               due = cyc + ((rd_lat < 0) ? int'($urandom_range(1, 30)) : rd_lat);
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               ret_q.push_back('{due, mig_mem.exists(a) ? mig_mem[a] : init_val(a)});
            end
         end

         if (wdf_wren && wdf_rdy) begin
            chk("wdf_end", wdf_end, 1);
            chk("wdf_expected", wd_q.size() != 0, 1);
            if (wd_q.size() != 0) begin
               chk("wdf_data", wdf_data, wd_q.pop_front());
               chk("wdf_mask", wdf_mask, wm_q.pop_front());
            end
            mig_wd_q.push_back(wdf_data);
            mig_wm_q.push_back(wdf_mask);
         end
         while (mig_wa_q.size() != 0 && mig_wd_q.size() != 0) begin
            a = int'(mig_wa_q.pop_front());
            mig_mem[a] = merge(mig_mem.exists(a) ? mig_mem[a] : init_val(a),
                               mig_wd_q.pop_front(), mig_wm_q.pop_front());
         end

         if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", exp_rsp_q.size() != 0, 1);
            if (exp_rsp_q.size() != 0) chk("rsp_data", rsp_data, exp_rsp_q.pop_front());
         end

         prev_en = app_en & ~app_rdy;     h_addr = app_addr; h_cmd = app_cmd;
         prev_wr = wdf_wren & ~wdf_rdy;   h_data = wdf_data; h_mask = wdf_mask;
      end
   end

   // ---------------- stimulus ----------------
   int sent_wr = 0;
   int sent_rd = 0;

   // Called just after a negedge; returns after the accepting edge (or on timeout).
   task automatic send(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [MASK_W-1:0] m, input int budget, output bit acc);
      int w;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wmask = m;
      #1;
      w = 0;
      while (!req_ready && w < budget) begin
         @(negedge clk); #1; w++;
      end
      acc = req_ready;
      if (acc) begin
         if (wr) sent_wr++; else sent_rd++;
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int w;
      w = 0;
      #1;
      while ((cmd_q.size() != 0 || exp_rsp_q.size() != 0 || ret_q.size() != 0 || !req_ready) && w < 3000) begin
         @(negedge clk); #1; w++;
      end
      chk(tag, w < 3000, 1);
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      return ADDR_W'(32'h1000 + $urandom_range(0, 7) * 16);
   endfunction

   initial begin
      bit                acc;
      int                bad, w, base_wr, base_rd, base_en, base_wren, nacc;
      logic [DATA_W-1:0] d;
      logic [31:0]       exp_wr, exp_rd;

      sys_rst = 1'b0; calib = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_wmask = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_app_en", app_en, 0);
      chk("rst_app_cmd", app_cmd, 0);
      chk("rst_wren", wdf_wren, 0);
      chk("rst_wdf_end", wdf_end, 0);
      chk("rst_hi_pri", app_hi_pri, 0);
      chk("rst_app_addr", app_addr, 0);
      chk("rst_stat_wr", stat_wr, 0);
      chk("rst_stat_rd", stat_rd, 0);
      @(negedge clk);
      sys_rst = 1'b1;

      // Calibration hold: request pending, nothing must happen.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 28'h40;
      bad = 0;
      repeat (100) begin
         @(negedge clk); #1;
         if (req_ready || app_en) bad++;
      end
      chk("calib_hold", bad, 0);
      calib = 1'b1;
      w = 0;
      while (!req_ready && w < 5) begin
         @(negedge clk); #1; w++;
      end
      chk("calib_ready_latency", w, 1);
      sent_rd++;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle("idle_after_calib");

      // Write with command stalled for five cycles, data accepted at once.
      app_pct = 0; wdf_pct = 100;
      base_en = cnt_en; base_wren = cnt_wren; base_wr = n_wr_cmd;
      send(1'b1, 28'h100, {80{8'hA5}}, '0, 10, acc);
      chk("w100_accepted", acc, 1);
      repeat (4) @(negedge clk);
      app_pct = 100;
      repeat (6) @(negedge clk);
      #1;
      chk("w100_app_en_cycles", cnt_en - base_en, 6);
      chk("w100_wren_cycles", cnt_wren - base_wren, 1);
      chk("w100_single_cmd", n_wr_cmd - base_wr, 1);
      chk("w100_back_idle", req_ready, 1);

      // Read back a known value after a 20-cycle MIG latency.
      d = rand_data();
      @(negedge clk);
      send(1'b1, 28'h2A0, d, '0, 20, acc);
      wait_idle("idle_after_w2a0");
      rd_lat = 20; rsp_pct = 0;
      @(negedge clk);
      send(1'b0, 28'h2A0, '0, '0, 20, acc);
      w = 0; #1;
      while (!rsp_valid && w < 100) begin
         @(negedge clk); #1; w++;
      end
      chk("r2a0_rsp_valid", rsp_valid, 1);
      chk("r2a0_latency_ge20", w >= 20, 1);
      chk("r2a0_rsp_data", rsp_data, d);
      chk("r2a0_credit_held", dut.r_credit, 15);
      rsp_pct = 100;
      wait_idle("idle_after_r2a0");
      chk("r2a0_credit_back", dut.r_credit, 16);

      // Credit exhaustion: 16 reads outstanding, 17th must wait for a pop.
      rd_lat = 3; rsp_pct = 0; base_rd = n_rd_cmd; nacc = 0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         send(1'b0, ADDR_W'(32'h800 + i * 16), '0, '0, 20, acc);
         nacc += int'(acc);
      end
      chk("rd16_accepted", nacc, 16);
      repeat (40) @(negedge clk);
      chk("rd16_issued", n_rd_cmd - base_rd, 16);
      send(1'b0, 28'h900, '0, '0, 10, acc);
      chk("rd17_blocked", acc, 0);
      chk("rd17_ready_low", req_ready, 0);
      rsp_pct = 100;
      @(negedge clk);
      rsp_pct = 0;
      send(1'b0, 28'h900, '0, '0, 10, acc);
      chk("rd17_after_pop", acc, 1);
      rsp_pct = 100; rd_lat = 5;
      wait_idle("idle_after_rd17");

      // Calibration lost during a write: the write finishes, then CALIB.
      app_pct = 0; base_wr = n_wr_cmd;
      @(negedge clk);
      send(1'b1, 28'h180, rand_data(), rand_mask(), 20, acc);
      calib = 1'b0;
      repeat (3) @(negedge clk);
      app_pct = 100;
      repeat (5) @(negedge clk);
      #1;
      chk("calib_drop_write_done", n_wr_cmd - base_wr, 1);
      chk("calib_drop_state", dut.r_state, ST_CALIB);
      chk("calib_drop_ready", req_ready, 0);
      calib = 1'b1;
      wait_idle("idle_after_calib_drop");

      // Asynchronous reset in the middle of a stalled write.
      app_pct = 0;
      @(negedge clk);
      send(1'b1, 28'h3F0, rand_data(), '0, 20, acc);
      #3 sys_rst = 1'b0;
      #1;
      chk("arst_app_en", app_en, 0);
      chk("arst_wren", wdf_wren, 0);
      chk("arst_state", dut.r_state, ST_CALIB);
      chk("arst_credit", dut.r_credit, 16);
      chk("arst_req_ready", req_ready, 0);
      @(negedge clk);
      @(negedge clk);
      sys_rst = 1'b1; app_pct = 100;
      sent_wr = 0; sent_rd = 0;
      wait_idle("idle_after_arst");

      // Three writes and five reads for the statistics counters.
      @(negedge clk);
      for (int i = 0; i < 3; i++) send(1'b1, rand_addr(), rand_data(), rand_mask(), 50, acc);
      for (int i = 0; i < 5; i++) send(1'b0, rand_addr(), '0, '0, 50, acc);
      wait_idle("idle_after_stats");
`ifdef DDR4_APP_MASTER_STATS_EN
      exp_wr = 32'd3; exp_rd = 32'd5;
`else
      exp_wr = 32'd0; exp_rd = 32'd0;
`endif
      chk("stat_wr_3", stat_wr, exp_wr);
      chk("stat_rd_5", stat_rd, exp_rd);

      // Randomized traffic against the memory model.
      rd_lat = -1;
      @(negedge clk);
      for (int i = 0; i < 300; i++) begin
         if (i % 50 == 0) begin
            app_pct = $urandom_range(30, 100);
            wdf_pct = $urandom_range(30, 100);
            rsp_pct = $urandom_range(20, 100);
         end
         send($urandom_range(1), rand_addr(), rand_data(), rand_mask(), 300, acc);
         chk("rand_accepted", acc, 1);
         if ($urandom_range(3) == 0) @(negedge clk);
      end
      app_pct = 100; wdf_pct = 100; rsp_pct = 100;
      wait_idle("idle_after_random");
`ifdef DDR4_APP_MASTER_STATS_EN
      exp_wr = 32'(sent_wr); exp_rd = 32'(sent_rd);
`else
      exp_wr = 32'd0; exp_rd = 32'd0;
`endif
      chk("stat_wr_total", stat_wr, exp_wr);
      chk("stat_rd_total", stat_rd, exp_rd);
      chk("hi_pri_final", app_hi_pri, 0);
      chk("credit_final", dut.r_credit, 16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
